// File: rtl/escalonador_processos.sv
// Round-robin process scheduler: dispatches ready user processes from the SO partition,
// counts retired instructions per time slice and pulses context save/restore on each switch.
module escalonador_processos #(
    parameter int QUANTUM  = 16,
    parameter int NUM_PROC = 13
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Habilita,
    input  logic        Instr_Valid,
    input  logic [12:0] Proc_Pronto,
    input  logic        Fim_Processo,
    output logic [3:0]  Indice_Processo,
    output logic        Change_Offset,
    output logic        Salvar_Contexto,
    output logic        Carregar_Contexto,
    output logic        Em_SO,
    output logic [7:0]  Contador_Quantum
);

    typedef enum logic [2:0] {SO, BUSCA, CARREGA, EXEC, SALVA} estado_t;

    localparam logic [13:0] MASCARA_LARGA = (14'd1 << NUM_PROC) - 14'd1;

    estado_t     estado, prox_estado;
    logic [3:0]  ultimo, prox_ultimo;
    logic [3:0]  candidato, prox_candidato;
    logic [3:0]  testados, prox_testados;
    logic [3:0]  prox_indice;
    logic        prox_change, prox_salvar, prox_carregar, prox_em_so;
    logic [7:0]  prox_contador;
    logic [15:0] pronto_valido;
    logic [3:0]  cand_idx;
    logic        cand_pronto;

    // Zero-extended to 16 bits so any 4-bit candidate index stays in range.
    assign pronto_valido = {3'b000, Proc_Pronto & MASCARA_LARGA[12:0]};
    assign cand_idx      = candidato - 4'd1;
    assign cand_pronto   = pronto_valido[cand_idx];

    function automatic logic [3:0] seguinte(input logic [3:0] p);
        return (p >= 4'(NUM_PROC)) ? 4'd1 : p + 4'd1;
    endfunction

    always_comb begin
        prox_estado    = estado;
        prox_ultimo    = ultimo;
        prox_candidato = candidato;
        prox_testados  = testados;
        prox_indice    = Indice_Processo;
        prox_em_so     = Em_SO;
        prox_contador  = Contador_Quantum;
        prox_change    = 1'b0;
        prox_salvar    = 1'b0;
        prox_carregar  = 1'b0;
        case (estado)
            SO: begin
                if (Habilita && (|pronto_valido)) begin
                    prox_estado    = BUSCA;
                    prox_candidato = seguinte(ultimo);
                    prox_testados  = 4'd0;
                end
            end
            BUSCA: begin
                if (cand_pronto) begin
                    prox_estado   = CARREGA;
                    prox_indice   = candidato;
                    prox_ultimo   = candidato;
                    prox_change   = 1'b1;
                    prox_carregar = 1'b1;
                    prox_em_so    = 1'b0;
                    prox_contador = 8'd0;
                end else if (testados == 4'(NUM_PROC - 1)) begin
                    prox_estado = SO;
                end else begin
                    prox_candidato = seguinte(candidato);
                    prox_testados  = testados + 4'd1;
                end
            end
            CARREGA: prox_estado = EXEC;
            EXEC: begin
                // Saturates at QUANTUM; expiry and termination share one SALVA.
                if (Instr_Valid && (Contador_Quantum != 8'(QUANTUM)))
                    prox_contador = Contador_Quantum + 8'd1;
                if (Fim_Processo || (Instr_Valid && (Contador_Quantum == 8'(QUANTUM - 1)))) begin
                    prox_estado = SALVA;
                    prox_salvar = 1'b1;
                    prox_change = 1'b1;
                    prox_indice = 4'd0;
                    prox_em_so  = 1'b1;
                end
            end
            SALVA: prox_estado = SO;
            default: begin
                prox_estado = SO;
                prox_indice = 4'd0;
                prox_em_so  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            estado            <= SO;
            ultimo            <= 4'd0;
            candidato         <= 4'd1;
            testados          <= 4'd0;
            Indice_Processo   <= 4'd0;
            Em_SO             <= 1'b1;
            Contador_Quantum  <= 8'd0;
            Change_Offset     <= 1'b0;
            Salvar_Contexto   <= 1'b0;
            Carregar_Contexto <= 1'b0;
        end else begin
            estado            <= prox_estado;
            ultimo            <= prox_ultimo;
            candidato         <= prox_candidato;
            testados          <= prox_testados;
            Indice_Processo   <= prox_indice;
            Em_SO             <= prox_em_so;
            Contador_Quantum  <= prox_contador;
            Change_Offset     <= prox_change;
            Salvar_Contexto   <= prox_salvar;
            Carregar_Contexto <= prox_carregar;
        end
    end

endmodule

// File: tb/tb_escalonador_processos.sv
// Self-checking bench for escalonador_processos: table of dispatch/slice vectors,
// a dispatch-order scoreboard, and hand sequences for empty scan and async reset.
module tb_escalonador_processos;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Habilita = 1'b0;
    logic        Instr_Valid = 1'b0;
    logic [12:0] Proc_Pronto = 13'h0;
    logic        Fim_Processo = 1'b0;
    logic [3:0]  Indice_Processo;
    logic        Change_Offset;
    logic        Salvar_Contexto;
    logic        Carregar_Contexto;
    logic        Em_SO;
    logic [7:0]  Contador_Quantum;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    logic change_ant = 1'b0;

    typedef struct {
        logic [12:0] pronto;
        int          exp_idx;
        int          exp_lat;
        int          n_instr;
        bit          fim;
        int          exp_cnt;
    } vetor_t;

    vetor_t tabela[7];

    escalonador_processos #(.QUANTUM(16), .NUM_PROC(13)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Habilita(Habilita),
        .Instr_Valid(Instr_Valid),
        .Proc_Pronto(Proc_Pronto),
        .Fim_Processo(Fim_Processo),
        .Indice_Processo(Indice_Processo),
        .Change_Offset(Change_Offset),
        .Salvar_Contexto(Salvar_Contexto),
        .Carregar_Contexto(Carregar_Contexto),
        .Em_SO(Em_SO),
        .Contador_Quantum(Contador_Quantum)
    );

    always #5 Clock = ~Clock;

    task automatic check_output(input string nome, input int atual, input int esperado);
        checks++;
        if (atual != esperado) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", nome, atual, esperado);
        end
    endtask

    // Scoreboard pops the expected process on every restore pulse and watches pulse invariants.
    always @(negedge Clock) begin
        if (Carregar_Contexto) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_dispatch", int'(Indice_Processo), -1);
            end else begin
                check_output("dispatch_order", int'(Indice_Processo), exp_q.pop_front());
            end
            check_output("save_and_load_together", int'(Salvar_Contexto), 0);
        end
        if (Change_Offset)
            check_output("change_offset_spacing", int'(change_ant), 0);
        change_ant = Change_Offset;
    end

    // Called at a falling edge while in SO; returns at the falling edge that shows CARREGA.
    task automatic apply_stimulus(input logic [12:0] pronto, input int exp_idx, input int exp_lat);
        int lat;
        bit achou;
        lat = 0;
        achou = 1'b0;
        Proc_Pronto = pronto;
        Habilita = 1'b1;
        exp_q.push_back(exp_idx);
        for (int k = 0; k < 40 && !achou; k++) begin
            @(negedge Clock);
            lat++;
            if (Carregar_Contexto) achou = 1'b1;
        end
        if (!achou) check_output("dispatch_timeout", lat, exp_lat);
        check_output("dispatch_latency", lat, exp_lat);
        check_output("carrega_change", int'(Change_Offset), 1);
        check_output("carrega_em_so", int'(Em_SO), 0);
        check_output("carrega_contador", int'(Contador_Quantum), 0);
        check_output("carrega_indice", int'(Indice_Processo), exp_idx);
    endtask

    // Starts in CARREGA; runs one slice and ends at the falling edge after SALVA (back in SO).
    task automatic run_slice(input int idx, input int n, input bit fim, input int exp_cnt);
        Instr_Valid = 1'b1;
        Fim_Processo = 1'b1;
        Habilita = 1'b0;
        @(negedge Clock);
        check_output("exec_counter_start", int'(Contador_Quantum), 0);
        check_output("exec_no_change", int'(Change_Offset), 0);
        check_output("exec_indice", int'(Indice_Processo), idx);
        for (int i = 0; i < n; i++) begin
            if (i % 4 == 3) begin
                Instr_Valid = 1'b0;
                Fim_Processo = 1'b0;
                @(negedge Clock);
                check_output("exec_idle_no_save", int'(Salvar_Contexto), 0);
            end
            Instr_Valid = 1'b1;
            Fim_Processo = fim && (i == n - 1);
            @(negedge Clock);
            if (i < n - 1) begin
                check_output("exec_counter", int'(Contador_Quantum), i + 1);
                check_output("exec_no_save", int'(Salvar_Contexto), 0);
            end
        end
        check_output("salva_pulse", int'(Salvar_Contexto), 1);
        check_output("salva_change", int'(Change_Offset), 1);
        check_output("salva_indice", int'(Indice_Processo), 0);
        check_output("salva_em_so", int'(Em_SO), 1);
        check_output("salva_counter", int'(Contador_Quantum), exp_cnt);
        Instr_Valid = 1'b0;
        Fim_Processo = 1'b0;
        @(negedge Clock);
        check_output("so_single_save", int'(Salvar_Contexto), 0);
        check_output("so_no_change", int'(Change_Offset), 0);
        check_output("so_em_so", int'(Em_SO), 1);
    endtask

    initial begin
        int lat;
        bit achou;

        tabela[0] = '{13'h0004,  3,  4, 16, 1'b0, 16};
        tabela[1] = '{13'h1001, 13, 11,  5, 1'b1,  5};
        tabela[2] = '{13'h1001,  1,  2, 16, 1'b1, 16};
        tabela[3] = '{13'h1001, 13, 13, 16, 1'b0, 16};
        tabela[4] = '{13'h1FFF,  1,  2,  1, 1'b1,  1};
        tabela[5] = '{13'h0010,  5,  5, 16, 1'b0, 16};
        tabela[6] = '{13'h0008,  4, 13,  3, 1'b1,  3};

        repeat (3) @(negedge Clock);
        check_output("reset_indice", int'(Indice_Processo), 0);
        check_output("reset_em_so", int'(Em_SO), 1);
        check_output("reset_counter", int'(Contador_Quantum), 0);
        check_output("reset_pulses", int'({Change_Offset, Salvar_Contexto, Carregar_Contexto}), 0);
        Reset = 1'b1;
        @(negedge Clock);

        foreach (tabela[v]) begin
            apply_stimulus(tabela[v].pronto, tabela[v].exp_idx, tabela[v].exp_lat);
            run_slice(tabela[v].exp_idx, tabela[v].n_instr, tabela[v].fim, tabela[v].exp_cnt);
        end

        // Ready set withdrawn as the scan starts: full empty scan, then back to SO.
        Proc_Pronto = 13'h0004;
        Habilita = 1'b1;
        @(negedge Clock);
        Proc_Pronto = 13'h0000;
        for (int k = 0; k < 13; k++) begin
            @(negedge Clock);
            check_output("empty_scan_no_change", int'(Change_Offset), 0);
            check_output("empty_scan_em_so", int'(Em_SO), 1);
        end
        apply_stimulus(13'h1FFF, 5, 2);
        run_slice(5, 2, 1'b1, 2);

        // Only process 5 ready: hit on the 13th candidate, then async reset mid-slice.
        apply_stimulus(13'h0010, 5, 14);
        Instr_Valid = 1'b0;
        Habilita = 1'b0;
        @(negedge Clock);
        Instr_Valid = 1'b1;
        repeat (3) @(negedge Clock);
        check_output("pre_reset_counter", int'(Contador_Quantum), 3);
        #2 Reset = 1'b0;
        #1;
        check_output("async_reset_indice", int'(Indice_Processo), 0);
        check_output("async_reset_em_so", int'(Em_SO), 1);
        check_output("async_reset_counter", int'(Contador_Quantum), 0);
        Instr_Valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clock);
            check_output("reset_no_save", int'(Salvar_Contexto), 0);
        end
        Reset = 1'b1;

        // Habilita low holds SO even with processes ready; first dispatch scans from 1.
        Proc_Pronto = 13'h1FFF;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clock);
            check_output("disabled_no_dispatch", int'(Carregar_Contexto), 0);
            check_output("disabled_em_so", int'(Em_SO), 1);
        end
        apply_stimulus(13'h1FFF, 1, 2);
        run_slice(1, 2, 1'b1, 2);

        check_output("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule
